// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among NUM_REQ producers, with burst lock
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   reset_i      asynchronous active-high reset
//   req_i        per-requester write request, held with data until granted
//   last_i       per-requester final-beat flag, qualified by req_i
//   data_i       flattened requester data, requester k at [k*WIDTH +: WIDTH]
//   gnt_o        one-hot combinational accept
//   fifo_full_i  fifo full flag
//   fifo_wr_o    fifo write strobe (|gnt_o)
//   fifo_data_o  data of the granted requester, 0 when nothing is granted
//   owner_o      registered lock owner index
//   busy_o       high while a requester holds the lock
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int IDX_LEN   = 2,
    parameter int MAX_BURST = 4,
    parameter int CNT_LEN   = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       last_i,
    input  logic [NUM_REQ*WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_o,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic [IDX_LEN-1:0]       owner_o,
    output logic                     busy_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDX_LEN-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_LEN-1:0] owner_q, owner_d;
    logic [CNT_LEN-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_LEN-1:0] beat_nxt;
    logic [IDX_LEN-1:0] win;
    logic               found;
    logic [NUM_REQ-1:0] gnt;
    int                 k;

    function automatic logic [IDX_LEN-1:0] next_idx(input logic [IDX_LEN-1:0] x);
        return (x == IDX_LEN'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr, wrapping explicitly at NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req_i[k]) begin
                found = 1'b1;
                win   = IDX_LEN'(k);
            end
        end
    end

    assign beat_nxt = beat_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        gnt        = '0;
        if (state_q == IDLE) begin
            if (found && !fifo_full_i) begin
                gnt[win] = 1'b1;
                if (last_i[win] || MAX_BURST == 1) begin
                    rr_ptr_d = next_idx(win);
                end else begin
                    state_d    = LOCKED;
                    owner_d    = win;
                    beat_cnt_d = CNT_LEN'(1);
                end
            end
        end else if (!req_i[owner_q]) begin
            // Owner gave up the lock: release now, re-arbitrate next cycle
            state_d    = IDLE;
            rr_ptr_d   = next_idx(owner_q);
            beat_cnt_d = '0;
        end else if (!fifo_full_i) begin
            gnt[owner_q] = 1'b1;
            beat_cnt_d   = beat_nxt;
            if (last_i[owner_q] || beat_nxt == CNT_LEN'(MAX_BURST)) begin
                state_d    = IDLE;
                rr_ptr_d   = next_idx(owner_q);
                beat_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Grant is combinational, so it must be masked while reset is held
    assign gnt_o     = reset_i ? '0 : gnt;
    assign fifo_wr_o = |gnt_o;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q == LOCKED);

    always_comb begin
        fifo_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_data_o = fifo_data_o | (data_i[i*WIDTH +: WIDTH] & {WIDTH{gnt_o[i]}});
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven, scoreboard-checked bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4)
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  req_i, last_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic        fifo_full_i, fifo_wr_o, busy_o;
    logic [7:0]  fifo_data_o;
    logic [1:0]  owner_o;

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .IDX_LEN(2), .MAX_BURST(4), .CNT_LEN(3)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .last_i(last_i), .data_i(data_i),
        .gnt_o(gnt_o), .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o),
        .fifo_data_o(fifo_data_o), .owner_o(owner_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req, last;
        logic       full;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t       vecs[$];
    vec_t       sb[$];
    logic [7:0] dat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         n_vec = 0;
    int         n_err = 0;
    int         cur = 0;

    function automatic vec_t mk(logic [3:0] r, logic [3:0] l, logic f, logic [3:0] g, logic b, logic [1:0] o);
        vec_t v;
        v.req = r; v.last = l; v.full = f; v.gnt = g; v.busy = b; v.owner = o;
        return v;
    endfunction

    function automatic logic [7:0] mux_model(logic [3:0] g);
        logic [7:0] d = '0;
        for (int i = 0; i < 4; i++) if (g[i]) d |= dat[i];
        return d;
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s actual=%0h required=%0h", cur, nm, act, exp);
        end
    endfunction

    task automatic sample();
        vec_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("gnt", 32'(gnt_o), 32'(e.gnt));
        check("wr", 32'(fifo_wr_o), 32'(|e.gnt));
        check("data", 32'(fifo_data_o), 32'(mux_model(e.gnt)));
        check("busy", 32'(busy_o), 32'(e.busy));
        check("owner", 32'(owner_o), 32'(e.owner));
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        req_i = t.req; last_i = t.last; fifo_full_i = t.full;
        sb.push_back(t);
        #2 sample();
    endtask

    initial begin
        data_i = {dat[3], dat[2], dat[1], dat[0]};
        reset_i = 1'b1; req_i = 4'hF; last_i = 4'hF; fifo_full_i = 1'b0;
        // outputs held at zero during reset even with requests present
        sb.push_back(mk(4'hF, 4'hF, 0, 4'h0, 0, 2'd0));
        #2 sample();
        @(negedge clk);
        reset_i = 1'b0; req_i = 4'h0; last_i = 4'h0;

        // round-robin fairness
        for (int i = 0; i < 8; i++) vecs.push_back(mk(4'hF, 4'hF, 0, 4'(1 << (i % 4)), 0, 2'd0));
        // burst lock capped at 4 beats, alternating owners
        vecs.push_back(mk(4'h3, 4'h0, 0, 4'h1, 0, 2'd0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'h3, 4'h0, 0, 4'h1, 1, 2'd0));
        vecs.push_back(mk(4'h3, 4'h0, 0, 4'h2, 0, 2'd0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'h3, 4'h0, 0, 4'h2, 1, 2'd1));
        vecs.push_back(mk(4'h3, 4'h0, 0, 4'h1, 0, 2'd1));
        vecs.push_back(mk(4'h1, 4'h1, 0, 4'h1, 1, 2'd0));
        // early last from requester 2, then rr_ptr=3 favours requester 3
        vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 0, 2'd0));
        vecs.push_back(mk(4'h4, 4'h4, 0, 4'h4, 1, 2'd2));
        vecs.push_back(mk(4'h9, 4'h9, 0, 4'h8, 0, 2'd2));
        // full backpressure mid-burst keeps lock and beat count
        vecs.push_back(mk(4'h2, 4'h0, 0, 4'h2, 0, 2'd2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'h3, 4'h0, 1, 4'h0, 1, 2'd1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'h3, 4'h0, 0, 4'h2, 1, 2'd1));
        vecs.push_back(mk(4'h3, 4'h3, 0, 4'h1, 0, 2'd1));
        vecs.push_back(mk(4'hF, 4'hF, 1, 4'h0, 0, 2'd1));
        // owner drop releases the lock, rr_ptr wraps 3 -> 0
        vecs.push_back(mk(4'h8, 4'h0, 0, 4'h8, 0, 2'd1));
        vecs.push_back(mk(4'h1, 4'h0, 0, 4'h0, 1, 2'd3));
        vecs.push_back(mk(4'h9, 4'h9, 0, 4'h1, 0, 2'd3));
        // lock requester 2 ahead of the async reset
        vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 0, 2'd3));

        foreach (vecs[i]) begin
            cur = i;
            apply(vecs[i]);
        end

        // async reset between edges while LOCKED
        cur = 1000;
        @(negedge clk);
        req_i = 4'h5; last_i = 4'h0; fifo_full_i = 1'b0;
        #2 reset_i = 1'b1;
        sb.push_back(mk(4'h5, 4'h0, 0, 4'h0, 0, 2'd0));
        #1 sample();
        cur = 1001;
        @(negedge clk);
        reset_i = 1'b0; last_i = 4'h5;
        sb.push_back(mk(4'h5, 4'h5, 0, 4'h1, 0, 2'd0));
        #2 sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
